// File: rtl/hv_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hv_cmd_pkg
// Description : Shared definitions for the command fetch path: BSM opcodes,
//               completion status codes, CDB field layout, fetch FSM states
//               and a saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package hv_cmd_pkg;

    // Opcodes carried in CDB[7:0]
    localparam logic [7:0] BSM_WRITE = 8'h40;
    localparam logic [7:0] BSM_READ  = 8'h30;
    localparam logic [7:0] QUERY     = 8'h70;

    // Completion status codes returned to the queue
    localparam logic [7:0] CMD_ST_READ_DONE  = 8'h06;
    localparam logic [7:0] CMD_ST_WRITE_DONE = 8'h07;
    localparam logic [7:0] CMD_ST_CKSUM_ERR  = 8'hE1;
    localparam logic [7:0] CMD_ST_OP_ERR     = 8'hE2;
    localparam logic [7:0] CMD_ST_EXEC_ERR   = 8'hE3;

    // CDB layout: 256 bits, eight 32-bit words, word 4 carries the checksum
    localparam int CDB_WIDTH      = 256;
    localparam int CDB_BEATS      = 4;
    localparam int CDB_WORD_W     = 32;
    localparam int CDB_WORDS      = CDB_WIDTH / CDB_WORD_W;
    localparam int CDB_OPCODE_LSB = 0;
    localparam int CDB_TAG_LSB    = 8;
    localparam int CDB_CKSUM_LSB  = 128;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ      = 3'd1,
        ST_WAIT_OE  = 3'd2,
        ST_CAPTURE  = 3'd3,
        ST_CHECK    = 3'd4,
        ST_DISPATCH = 3'd5,
        ST_EXEC     = 3'd6,
        ST_REPORT   = 3'd7
    } fetch_state_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hv_cdb_check.sv
`default_nettype none
// ============================================================================
// Module      : hv_cdb_check
// Description : Combinational CDB validation. The XOR of all eight 32-bit
//               words must be zero for a valid checksum; only BSM_WRITE and
//               BSM_READ are executable opcodes on this path.
// Ports       : cdb_i        - captured 256-bit CDB
//               cksum_ok_o   - 1 when the word XOR folds to zero
//               op_valid_o   - 1 when the opcode is BSM_WRITE or BSM_READ
//               op_is_read_o - 1 when the opcode is BSM_READ
// Revision    : 1.0 - initial release
// ============================================================================
module hv_cdb_check
    import hv_cmd_pkg::*;
(
    input  logic [CDB_WIDTH-1:0] cdb_i,
    output logic                 cksum_ok_o,
    output logic                 op_valid_o,
    output logic                 op_is_read_o
);

    logic [CDB_WORD_W-1:0] fold;
    logic [7:0]            opcode;

    always_comb begin
        fold = '0;
        for (int i = 0; i < CDB_WORDS; i++) begin
            fold = fold ^ cdb_i[i*CDB_WORD_W +: CDB_WORD_W];
        end
    end

    assign opcode       = cdb_i[CDB_OPCODE_LSB +: 8];
    assign cksum_ok_o   = (fold == '0);
    // QUERY is deliberately rejected: queries travel on the queue's query port
    assign op_valid_o   = (opcode == BSM_WRITE) || (opcode == BSM_READ);
    assign op_is_read_o = (opcode == BSM_READ);

endmodule
`default_nettype wire

// File: rtl/hv_cmd_fetch.sv
`default_nettype none
// ============================================================================
// Module      : hv_cmd_fetch
// Description : Consumer engine at the output of hv_commandQ. Requests a
//               command, captures the 4-beat CDB, validates it, dispatches
//               it to the BSM backend and reports status/tag to the queue.
// Config      : HV_FETCH_TIMEOUT_EN - abandon a request after OE_TIMEOUT
//               cycles without cmd_oe (counts as an error).
// Ports       : clk, reset (async, active low)
//               cq_cout_ready / cmd_request / cmd_oe / cmd_out - queue side
//               op_index / cmd_op_status / op_status_we        - status back
//               exe_* - backend handshake and command fields
//               err_count - saturating error counter
// Revision    : 1.0 - initial release
// ============================================================================
module hv_cmd_fetch
    import hv_cmd_pkg::*;
#(
    parameter int CMD_IO_WIDTH = 64,
    parameter int OE_TIMEOUT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cq_cout_ready,
    output logic                    cmd_request,
    input  logic                    cmd_oe,
    input  logic [CMD_IO_WIDTH-1:0] cmd_out,
    output logic [7:0]              op_index,
    output logic [7:0]              cmd_op_status,
    output logic                    op_status_we,
    output logic                    exe_valid,
    input  logic                    exe_ready,
    output logic [7:0]              exe_opcode,
    output logic [7:0]              exe_tag,
    output logic [CDB_WIDTH-1:0]    exe_cdb,
    input  logic                    exe_done,
    input  logic                    exe_error,
    output logic [7:0]              err_count
);

    fetch_state_e         state_q, state_d;
    logic [CDB_WIDTH-1:0] cdb_q, cdb_d;
    logic [1:0]           beat_q, beat_d;
    logic [7:0]           err_q, err_d;
    logic [7:0]           idx_q, idx_d;
    logic [7:0]           stat_q, stat_d;

    logic                 cksum_ok;
    logic                 op_valid;
    logic                 op_is_read;
    logic [CDB_WIDTH-1:0] cdb_shift;

`ifdef HV_FETCH_TIMEOUT_EN
    logic [7:0]           toc_q, toc_d;
`else
    logic                 unused_oe_timeout;
    assign unused_oe_timeout = (OE_TIMEOUT != 0);
`endif

    hv_cdb_check u_check (
        .cdb_i        (cdb_q),
        .cksum_ok_o   (cksum_ok),
        .op_valid_o   (op_valid),
        .op_is_read_o (op_is_read)
    );

    // Beats enter at the top and shift down; after four beats the first one
    // sits in CDB[63:0] and the last in CDB[255:192].
    assign cdb_shift = {cmd_out, cdb_q[CDB_WIDTH-1:CMD_IO_WIDTH]};

    always_comb begin
        state_d      = state_q;
        cdb_d        = cdb_q;
        beat_d       = beat_q;
        err_d        = err_q;
        idx_d        = idx_q;
        stat_d       = stat_q;
        cmd_request  = 1'b0;
        exe_valid    = 1'b0;
        op_status_we = 1'b0;
`ifdef HV_FETCH_TIMEOUT_EN
        toc_d        = toc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cq_cout_ready) state_d = ST_REQ;
            end
            ST_REQ: begin
                cmd_request = 1'b1;
                state_d     = ST_WAIT_OE;
`ifdef HV_FETCH_TIMEOUT_EN
                toc_d       = 8'd0;
`endif
            end
            ST_WAIT_OE: begin
                if (cmd_oe) begin
                    cdb_d   = cdb_shift;
                    beat_d  = 2'd1;
                    state_d = ST_CAPTURE;
                end
`ifdef HV_FETCH_TIMEOUT_EN
                else if (toc_q == 8'(OE_TIMEOUT - 1)) begin
                    err_d   = sat_inc8(err_q);
                    state_d = ST_IDLE;
                end else begin
                    toc_d = toc_q + 8'd1;
                end
`endif
            end
            ST_CAPTURE: begin
                if (cmd_oe) begin
                    cdb_d  = cdb_shift;
                    beat_d = beat_q + 2'd1;
                    if (beat_q == 2'd3) state_d = ST_CHECK;
                end else begin
                    // Broken burst: drop the frame silently apart from the counter
                    err_d   = sat_inc8(err_q);
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (!cksum_ok) begin
                    idx_d   = cdb_q[CDB_TAG_LSB +: 8];
                    stat_d  = CMD_ST_CKSUM_ERR;
                    err_d   = sat_inc8(err_q);
                    state_d = ST_REPORT;
                end else if (!op_valid) begin
                    idx_d   = cdb_q[CDB_TAG_LSB +: 8];
                    stat_d  = CMD_ST_OP_ERR;
                    err_d   = sat_inc8(err_q);
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                exe_valid = 1'b1;
                if (exe_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (exe_done) begin
                    idx_d = cdb_q[CDB_TAG_LSB +: 8];
                    if (exe_error) begin
                        stat_d = CMD_ST_EXEC_ERR;
                        err_d  = sat_inc8(err_q);
                    end else if (op_is_read) begin
                        stat_d = CMD_ST_READ_DONE;
                    end else begin
                        stat_d = CMD_ST_WRITE_DONE;
                    end
                    state_d = ST_REPORT;
                end
            end
            ST_REPORT: begin
                op_status_we = 1'b1;
                state_d      = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cdb_q   <= '0;
            beat_q  <= 2'd0;
            err_q   <= 8'd0;
            idx_q   <= 8'd0;
            stat_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            cdb_q   <= cdb_d;
            beat_q  <= beat_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            stat_q  <= stat_d;
        end
    end

`ifdef HV_FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) toc_q <= 8'd0;
        else        toc_q <= toc_d;
    end
`endif

    assign op_index      = idx_q;
    assign cmd_op_status = stat_q;
    assign err_count     = err_q;
    assign exe_opcode    = cdb_q[CDB_OPCODE_LSB +: 8];
    assign exe_tag       = cdb_q[CDB_TAG_LSB +: 8];
    assign exe_cdb       = cdb_q;

endmodule
`default_nettype wire

// File: tb/tb_hv_cmd_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hv_cmd_fetch
// Description : Self-checking bench for hv_cmd_fetch. A queue/backend driver
//               plays randomised commands; expected status, tag and error
//               count come from a plain-arithmetic reference of the command
//               rules. Build with HV_FETCH_TIMEOUT_EN to add the timeout case.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hv_cmd_fetch;
    import hv_cmd_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic         cq_cout_ready;
    logic         cmd_request;
    logic         cmd_oe;
    logic [63:0]  cmd_out;
    logic [7:0]   op_index;
    logic [7:0]   cmd_op_status;
    logic         op_status_we;
    logic         exe_valid;
    logic         exe_ready;
    logic [7:0]   exe_opcode;
    logic [7:0]   exe_tag;
    logic [255:0] exe_cdb;
    logic         exe_done;
    logic         exe_error;
    logic [7:0]   err_count;

    always #5 clk = ~clk;

    hv_cmd_fetch #(.CMD_IO_WIDTH(64), .OE_TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .cq_cout_ready(cq_cout_ready),
        .cmd_request(cmd_request), .cmd_oe(cmd_oe), .cmd_out(cmd_out),
        .op_index(op_index), .cmd_op_status(cmd_op_status),
        .op_status_we(op_status_we), .exe_valid(exe_valid),
        .exe_ready(exe_ready), .exe_opcode(exe_opcode), .exe_tag(exe_tag),
        .exe_cdb(exe_cdb), .exe_done(exe_done), .exe_error(exe_error),
        .err_count(err_count)
    );

    int         n_cmp = 0;
    int         n_mis = 0;
    int         n_strobes = 0;
    int         exp_reports = 0;
    logic [7:0] m_err = 8'd0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) if (reset && op_status_we) n_strobes++;

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic [7:0] m_inc(input logic [7:0] v);
        return (v == 8'hFF) ? 8'hFF : v + 8'd1;
    endfunction

    function automatic bit m_cksum_ok(input logic [255:0] c);
        logic [31:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) x ^= c[i*32 +: 32];
        return x == 32'd0;
    endfunction

    // Random CDB with the checksum word chosen to cancel the others
    function automatic logic [255:0] make_cdb(input logic [7:0] op, input logic [7:0] tag);
        logic [255:0] c;
        logic [31:0]  x;
        for (int i = 0; i < 8; i++) c[i*32 +: 32] = $urandom;
        c[7:0]  = op;
        c[15:8] = tag;
        x = '0;
        for (int i = 0; i < 8; i++) if (i != 4) x ^= c[i*32 +: 32];
        c[159:128] = x;
        return c;
    endfunction

    task automatic run_cmd(input logic [255:0] c, input int n_beats, input int gap,
                           input int rdy_dly, input int done_dly, input bit xerr,
                           input bit rst_in_exec);
        bit         seen;
        logic [7:0] op, tag, exp_st;
        bit         disp;
        op  = c[7:0];
        tag = c[15:8];
        cq_cout_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = cmd_request;
        end
        chk("req_seen", seen, 1'b1);
        cq_cout_ready = 1'b0;
        if (!seen) return;
        tick();
        chk("req_pulse", cmd_request, 1'b0);
        // Spurious completion while not executing must be ignored
        exe_done = (gap > 0);
        for (int i = 0; i < gap; i++) tick();
        exe_done = 1'b0;
        for (int b = 0; b < n_beats; b++) begin
            cmd_oe  = 1'b1;
            cmd_out = c[b*64 +: 64];
            tick();
        end
        cmd_oe  = 1'b0;
        cmd_out = {$urandom, $urandom};
        if (n_beats < 4) begin
            m_err = m_inc(m_err);
            tick();
            tick();
            chk("drop_err", err_count, m_err);
            return;
        end
        disp = 1'b0;
        if (!m_cksum_ok(c))                          exp_st = CMD_ST_CKSUM_ERR;
        else if (op != 8'h40 && op != 8'h30)         exp_st = CMD_ST_OP_ERR;
        else begin
            disp = 1'b1;
            if (xerr)              exp_st = CMD_ST_EXEC_ERR;
            else if (op == 8'h30)  exp_st = 8'h06;
            else                   exp_st = 8'h07;
        end
        tick();
        if (disp) begin
            chk("exe_valid", exe_valid, 1'b1);
            chk("exe_opcode", exe_opcode, op);
            chk("exe_tag", exe_tag, tag);
            chk("exe_cdb", exe_cdb, c);
            for (int i = 0; i < rdy_dly; i++) begin
                tick();
                chk("valid_hold", exe_valid, 1'b1);
                chk("cdb_hold", exe_cdb, c);
            end
            exe_ready = 1'b1;
            tick();
            exe_ready = 1'b0;
            chk("valid_drop", exe_valid, 1'b0);
            for (int i = 0; i < done_dly; i++) tick();
            if (rst_in_exec) begin
                #2 reset = 1'b0;
                #1;
                chk("rst_req", cmd_request, 1'b0);
                chk("rst_valid", exe_valid, 1'b0);
                chk("rst_we", op_status_we, 1'b0);
                chk("rst_idx", op_index, 8'd0);
                chk("rst_stat", cmd_op_status, 8'd0);
                chk("rst_err", err_count, 8'd0);
                chk("rst_cdb", exe_cdb, 256'd0);
                m_err = 8'd0;
                tick();
                reset = 1'b1;
                exe_done = 1'b1;
                tick();
                exe_done = 1'b0;
                tick();
                chk("rst_no_rpt", op_status_we, 1'b0);
                return;
            end
            exe_done  = 1'b1;
            exe_error = xerr;
            tick();
            exe_done  = 1'b0;
            exe_error = 1'b0;
        end else begin
            chk("no_dispatch", exe_valid, 1'b0);
        end
        if (exp_st[7:4] == 4'hE) m_err = m_inc(m_err);
        exp_reports++;
        chk("rpt_we", op_status_we, 1'b1);
        chk("rpt_idx", op_index, tag);
        chk("rpt_stat", cmd_op_status, exp_st);
        chk("rpt_err", err_count, m_err);
        tick();
        chk("rpt_end", op_status_we, 1'b0);
        chk("idx_hold", op_index, tag);
    endtask

    initial begin
        logic [255:0] c;
        logic [7:0]   op;
        int           kind;
        reset = 1'b0; cq_cout_ready = 1'b0; cmd_oe = 1'b0; cmd_out = '0;
        exe_ready = 1'b0; exe_done = 1'b0; exe_error = 1'b0;
        repeat (3) tick();
        chk("init_req", cmd_request, 1'b0);
        chk("init_valid", exe_valid, 1'b0);
        chk("init_we", op_status_we, 1'b0);
        chk("init_idx", op_index, 8'd0);
        chk("init_stat", cmd_op_status, 8'd0);
        chk("init_err", err_count, 8'd0);
        chk("init_cdb", exe_cdb, 256'd0);
        reset = 1'b1;
        tick();

        run_cmd(make_cdb(8'h40, 8'h00), 4, 0, 0, 1, 1'b0, 1'b0);
        for (int t = 0; t < 3; t++) run_cmd(make_cdb(8'h40, 8'(t)), 4, 0, 0, 0, 1'b0, 1'b0);
        chk("three_writes_err", err_count, 8'd0);
        c = make_cdb(8'h30, 8'h05);
        c[135:128] = ~c[135:128];
        run_cmd(c, 4, 1, 0, 0, 1'b0, 1'b0);
        run_cmd(make_cdb(8'h70, 8'h09), 4, 0, 0, 0, 1'b0, 1'b0);
        run_cmd(make_cdb(8'h40, 8'h11), 4, 0, 5, 2, 1'b0, 1'b0);
        run_cmd(make_cdb(8'h30, 8'h12), 4, 2, 1, 3, 1'b1, 1'b0);
        run_cmd(make_cdb(8'h40, 8'h13), 2, 0, 0, 0, 1'b0, 1'b0);
        run_cmd(make_cdb(8'h40, 8'h14), 4, 0, 1, 2, 1'b0, 1'b1);

`ifdef HV_FETCH_TIMEOUT_EN
        cq_cout_ready = 1'b1;
        for (int i = 0; i < 20 && !cmd_request; i++) tick();
        chk("to_req", cmd_request, 1'b1);
        cq_cout_ready = 1'b0;
        repeat (16) tick();
        chk("to_early", err_count, m_err);
        tick();
        m_err = m_inc(m_err);
        chk("to_fire", err_count, m_err);
        run_cmd(make_cdb(8'h40, 8'h21), 4, 0, 0, 0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            op   = ($urandom_range(0, 1) != 0) ? 8'h40 : 8'h30;
            c    = make_cdb(op, 8'($urandom));
            case (kind)
                0: c[$urandom_range(0, 255)] ^= 1'b1;
                1: begin
                    do op = 8'($urandom); while (op == 8'h40 || op == 8'h30);
                    c = make_cdb(op, 8'($urandom));
                end
                default: ;
            endcase
            run_cmd(c, (kind == 2) ? $urandom_range(1, 3) : 4, $urandom_range(0, 3),
                    $urandom_range(0, 4), $urandom_range(0, 4), kind == 3, 1'b0);
        end

        // Drive enough errors to reach saturation
        for (int n = 0; n < 260; n++) begin
            c = make_cdb(8'h40, 8'($urandom));
            c[40] = ~c[40];
            run_cmd(c, 4, 0, 0, 0, 1'b0, 1'b0);
        end
        chk("err_saturated", err_count, 8'hFF);
        chk("strobe_count", n_strobes, exp_reports);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
